// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM driving datapath muxes, write enables and ALU op.
// Optional CTRL_ILLEGAL_TRAP_EN adds an illegal output and a sticky TRAP state.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] immsrc,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic       illegal,
`endif
    output logic [2:0] alucontrol
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] JAL      = 4'd9;
    localparam logic [3:0] BEQ      = 4'd10;
    localparam logic [3:0] TRAP     = 4'd11;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic [3:0] state;
    logic [3:0] state_next;
    logic [1:0] aluop;
    logic       pcupdate;
    logic       branch;
    logic       irwrite_raw;
    logic       memwrite_raw;
    logic       regwrite_raw;
    logic       funct3_ok;

    assign funct3_ok = (funct3 == 3'b000) || (funct3 == 3'b110) ||
                       (funct3 == 3'b111);

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:   state_next = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_R:         state_next = EXECUTER;
                    OP_I:         state_next = EXECUTEI;
                    OP_JAL:       state_next = JAL;
                    OP_BEQ:       state_next = BEQ;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:      state_next = TRAP;
`else
                    default:      state_next = FETCH;
`endif
                endcase
            end
            MEMADR:  state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD: state_next = MEMWB;
            EXECUTER, EXECUTEI: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                state_next = funct3_ok ? ALUWB : TRAP;
`else
                state_next = ALUWB;
`endif
            end
            JAL:     state_next = ALUWB;
`ifdef CTRL_ILLEGAL_TRAP_EN
            TRAP:    state_next = TRAP;
`endif
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        adrsrc       = 1'b0;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        resultsrc    = 2'b00;
        alusrca      = 2'b00;
        alusrcb      = 2'b00;
        aluop        = 2'b00;
        pcupdate     = 1'b0;
        branch       = 1'b0;
        case (state)
            FETCH: begin
                irwrite_raw = 1'b1;
                alusrcb     = 2'b10;
                resultsrc   = 2'b10;
                pcupdate    = 1'b1;
            end
            DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
            end
            MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            MEMREAD:  adrsrc = 1'b1;
            MEMWB: begin
                resultsrc    = 2'b01;
                regwrite_raw = 1'b1;
            end
            MEMWRITE: begin
                adrsrc       = 1'b1;
                memwrite_raw = 1'b1;
            end
            EXECUTER: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
            end
            EXECUTEI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
            end
            ALUWB:    regwrite_raw = 1'b1;
            JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
            end
            BEQ: begin
                alusrca = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

    // Write strobes are squashed while reset is held, whatever the state.
    assign pcwrite  = ~reset & (pcupdate | (branch & zero));
    assign irwrite  = ~reset & irwrite_raw;
    assign memwrite = ~reset & memwrite_raw;
    assign regwrite = ~reset & regwrite_raw;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal = (state == TRAP);
`endif

    always_comb begin
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    always_comb begin
        alucontrol = 3'b000;
        case (aluop)
            2'b01: alucontrol = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alucontrol = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
                    3'b110:  alucontrol = 3'b011;
                    3'b111:  alucontrol = 3'b010;
                    default: alucontrol = 3'b000;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: vector table, corner sequences
// and randomized instructions against a per-instruction phase model.
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite;
    logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
    logic [2:0] alucontrol;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3),
        .funct7b5(funct7b5), .zero(zero), .pcwrite(pcwrite),
        .adrsrc(adrsrc), .memwrite(memwrite), .irwrite(irwrite),
        .regwrite(regwrite), .resultsrc(resultsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .immsrc(immsrc),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .illegal(illegal),
`endif
        .alucontrol(alucontrol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BQ  = 7'b1100011;

    typedef enum int {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB,
                      P_MEMWRITE, P_EXR, P_EXI, P_ALUWB, P_JAL, P_BEQ} phase_t;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] res;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] imm;
        logic [2:0] alu;
    } ctl_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         cpi;
        logic [2:0] alu2;
        logic [1:0] imm;
        logic       pcw2;
    } vec_t;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int cpi_of(input logic [6:0] o);
        case (o)
            LW:      return 5;
            SW, RT, IT, JL: return 4;
            BQ:      return 3;
            default: return 2;
        endcase
    endfunction

    function automatic phase_t phase_at(input logic [6:0] o, input int i);
        if (i == 0) return P_FETCH;
        if (i == 1) return P_DECODE;
        case (o)
            LW:      return (i == 2) ? P_MEMADR : (i == 3) ? P_MEMREAD : P_MEMWB;
            SW:      return (i == 2) ? P_MEMADR : P_MEMWRITE;
            RT:      return (i == 2) ? P_EXR : P_ALUWB;
            IT:      return (i == 2) ? P_EXI : P_ALUWB;
            JL:      return (i == 2) ? P_JAL : P_ALUWB;
            default: return P_BEQ;
        endcase
    endfunction

    // Operation the ALU should perform for a register/immediate arithmetic op.
    function automatic logic [2:0] arith_alu(input logic [6:0] o,
                                              input logic [2:0] f3,
                                              input logic f7);
        if (f3 == 3'd6) return 3'b011;
        if (f3 == 3'd7) return 3'b010;
        if (f3 == 3'd0 && o == RT && f7) return 3'b001;
        return 3'b000;
    endfunction

    function automatic ctl_t model(input phase_t p, input logic [6:0] o,
                                   input logic [2:0] f3, input logic f7,
                                   input logic z);
        ctl_t c;
        c = '0;
        c.imm = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 :
                (o == JL) ? 2'b11 : 2'b00;
        case (p)
            P_FETCH:    begin c.irw = 1; c.pcw = 1; c.sb = 2'b10; c.res = 2'b10; end
            P_DECODE:   begin c.sa = 2'b01; c.sb = 2'b01; end
            P_MEMADR:   begin c.sa = 2'b10; c.sb = 2'b01; end
            P_MEMREAD:  c.adr = 1;
            P_MEMWB:    begin c.res = 2'b01; c.rw = 1; end
            P_MEMWRITE: begin c.adr = 1; c.mw = 1; end
            P_EXR:      begin c.sa = 2'b10; c.alu = arith_alu(o, f3, f7); end
            P_EXI:      begin c.sa = 2'b10; c.sb = 2'b01; c.alu = arith_alu(o, f3, f7); end
            P_ALUWB:    c.rw = 1;
            P_JAL:      begin c.sa = 2'b01; c.sb = 2'b10; c.pcw = 1; end
            P_BEQ:      begin c.sa = 2'b10; c.alu = 3'b001; c.pcw = z; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctl_t actual();
        ctl_t c;
        c.pcw = pcwrite; c.adr = adrsrc; c.mw = memwrite; c.irw = irwrite;
        c.rw = regwrite; c.res = resultsrc; c.sa = alusrca; c.sb = alusrcb;
        c.imm = immsrc; c.alu = alucontrol;
        return c;
    endfunction

    // Entered and left during the low phase of a FETCH cycle.
    task automatic run_model(input logic [6:0] o, input logic [2:0] f3,
                             input logic f7);
        ctl_t e;
        for (int i = 0; i < cpi_of(o); i++) begin
            op = o; funct3 = f3; funct7b5 = f7; zero = 1'($urandom);
            #1;
            e = model(phase_at(o, i), o, f3, f7, zero);
            chk($sformatf("rand op=%b f3=%0d cyc=%0d", o, f3, i),
                32'(actual()), 32'(e));
            @(negedge clk);
        end
    endtask

    task automatic measure(input vec_t v, output int cpi,
                           output logic [2:0] alu2, output logic pcw2,
                           output logic [1:0] imm0);
        cpi = -1; alu2 = 'x; pcw2 = 'x; imm0 = 'x;
        for (int k = 0; k < 12; k++) begin
            op = v.op; funct3 = v.f3; funct7b5 = v.f7; zero = v.z;
            #1;
            if (k == 0) imm0 = immsrc;
            if (k == 2) begin alu2 = alucontrol; pcw2 = pcwrite; end
            if (k > 0 && irwrite) begin
                cpi = k;
                return;
            end
            @(negedge clk);
        end
    endtask

    vec_t vecs[$];
    logic [6:0] rops[$];

    initial begin
        int cpi;
        logic [2:0] a2;
        logic [1:0] im;
        logic pw;
        vec_t v;

        vecs.push_back('{RT, 3'd0, 1'b0, 1'b0, 4, 3'b000, 2'b00, 1'b0});
        vecs.push_back('{RT, 3'd0, 1'b1, 1'b0, 4, 3'b001, 2'b00, 1'b0});
        vecs.push_back('{RT, 3'd7, 1'b0, 1'b0, 4, 3'b010, 2'b00, 1'b0});
        vecs.push_back('{RT, 3'd6, 1'b0, 1'b1, 4, 3'b011, 2'b00, 1'b0});
        vecs.push_back('{IT, 3'd0, 1'b1, 1'b0, 4, 3'b000, 2'b00, 1'b0});
        vecs.push_back('{IT, 3'd7, 1'b0, 1'b0, 4, 3'b010, 2'b00, 1'b0});
        vecs.push_back('{IT, 3'd6, 1'b1, 1'b0, 4, 3'b011, 2'b00, 1'b0});
        vecs.push_back('{LW, 3'd2, 1'b0, 1'b1, 5, 3'b000, 2'b00, 1'b0});
        vecs.push_back('{SW, 3'd2, 1'b0, 1'b0, 4, 3'b000, 2'b01, 1'b0});
        vecs.push_back('{BQ, 3'd0, 1'b0, 1'b1, 3, 3'b001, 2'b10, 1'b1});
        vecs.push_back('{BQ, 3'd0, 1'b0, 1'b0, 3, 3'b001, 2'b10, 1'b0});
        vecs.push_back('{JL, 3'd0, 1'b0, 1'b0, 4, 3'b000, 2'b11, 1'b1});
        rops = '{LW, SW, RT, IT, JL, BQ};
`ifndef CTRL_ILLEGAL_TRAP_EN
        vecs.push_back('{7'b0000000, 3'd0, 1'b0, 1'b0, 2, 3'b000, 2'b00, 1'b0});
        vecs.push_back('{RT, 3'd1, 1'b1, 1'b0, 4, 3'b000, 2'b00, 1'b0});
        rops.push_back(7'b0000000);
        rops.push_back(7'b1110011);
`endif

        reset = 1'b1; op = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("reset_writes", {28'd0, pcwrite, irwrite, memwrite, regwrite}, 32'd0);
        end
        reset = 1'b0;
        #1;
        chk("post_reset_fetch", 32'(actual()),
            32'(model(P_FETCH, 7'd0, 3'd0, 1'b0, 1'b0)));

        foreach (vecs[i]) begin
            v = vecs[i];
            measure(v, cpi, a2, pw, im);
            chk($sformatf("vec%0d_cpi", i), 32'(cpi), 32'(v.cpi));
            chk($sformatf("vec%0d_imm", i), 32'(im), 32'(v.imm));
            if (v.cpi > 2) begin
                chk($sformatf("vec%0d_alu", i), 32'(a2), 32'(v.alu2));
                chk($sformatf("vec%0d_pcw", i), 32'(pw), 32'(v.pcw2));
            end
        end

        // Reset arriving during lw write-back must squash the register write.
        for (int i = 0; i < 4; i++) begin
            op = LW; #1;
            @(negedge clk);
        end
        chk("midreset_pre_wb", 32'(regwrite), 32'd1);
        reset = 1'b1;
        #1;
        chk("midreset_writes", {28'd0, pcwrite, irwrite, memwrite, regwrite}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_fetch", 32'(actual()),
            32'(model(P_FETCH, LW, 3'd0, 1'b0, 1'b0)));

        for (int n = 0; n < 150; n++) begin
            logic [2:0] f3;
            f3 = 3'($urandom);
`ifdef CTRL_ILLEGAL_TRAP_EN
            f3 = ($urandom_range(0, 2) == 0) ? 3'd0 :
                 ($urandom_range(0, 1) == 0) ? 3'd6 : 3'd7;
`endif
            run_model(rops[$urandom_range(0, rops.size() - 1)], f3, 1'($urandom));
        end

`ifdef CTRL_ILLEGAL_TRAP_EN
        op = 7'b0000000; #1;
        @(negedge clk); #1;
        chk("trap_decode_illegal", 32'(illegal), 32'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); zero = 1'b1; #1;
            chk("trap_illegal", 32'(illegal), 32'd1);
            chk("trap_writes", {28'd0, pcwrite, irwrite, memwrite, regwrite}, 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("trap_cleared", 32'(illegal), 32'd0);
        chk("trap_fetch", 32'(actual()),
            32'(model(P_FETCH, op, 3'd0, 1'b0, 1'b0)));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
